// File: rtl/led_pwm_dimmer_pkg.sv
// -----------------------------------------------------------------------------
// led_pwm_pkg
// Shared types and helpers for the LED PWM dimmer.
//   state_e   : cross-fade FSM states (IDLE, FADE_OUT, SWAP, FADE_IN)
//   SAT_W     : working width of the saturating helper (PWM_BITS must be <= SAT_W)
//   PWM_MAX   : largest level for the default 8-bit brightness resolution
//   sat_step  : saturating add (clamped to a ceiling) / subtract (clamped to a floor)
// -----------------------------------------------------------------------------
package led_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    SWAP     = 2'd2,
    FADE_IN  = 2'd3
  } state_e;

  localparam int SAT_W            = 16;
  localparam int PWM_BITS_DEFAULT = 8;
  localparam int unsigned PWM_MAX = (2 ** PWM_BITS_DEFAULT) - 1;

  // Arithmetic is done one bit wider than the operands so that the sum can
  // never wrap before it is compared with the ceiling.
  // up=1 : min(level + step, limit)
  // up=0 : max(level - step, limit)
  function automatic logic [SAT_W-1:0] sat_step(
    input logic [SAT_W-1:0] level,
    input logic [SAT_W-1:0] step,
    input logic [SAT_W-1:0] limit,
    input logic             up
  );
    logic [SAT_W:0] wide;
    if (up) begin
      wide = {1'b0, level} + {1'b0, step};
      if (wide > {1'b0, limit}) begin
        wide = {1'b0, limit};
      end else begin
        wide = wide;
      end
    end else begin
      if ({1'b0, level} > ({1'b0, step} + {1'b0, limit})) begin
        wide = {1'b0, level} - {1'b0, step};
      end else begin
        wide = {1'b0, limit};
      end
    end
    return wide[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/led_pwm_dimmer_if.sv
// -----------------------------------------------------------------------------
// led_pwm_dimmer_if
// Pattern handshake and LED drive bundle between pattern source and dimmer.
//   in_valid/in_ready/in_pattern : pattern transfer (valid/ready)
//   brightness                   : programmed target level
//   led_out                      : PWM-modulated LED pins
//   busy                         : a cross-fade is in progress
//   period_start                 : one-cycle pulse at each PWM period boundary
// master = pattern source side, slave = dimmer side.
// -----------------------------------------------------------------------------
interface led_pwm_dimmer_if #(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_pattern;
  logic [PWM_BITS-1:0] brightness;
  logic [WIDTH-1:0]    led_out;
  logic                busy;
  logic                period_start;

  modport master (
    output in_valid, in_pattern, brightness,
    input  in_ready, led_out, busy, period_start
  );

  modport slave (
    input  in_valid, in_pattern, brightness,
    output in_ready, led_out, busy, period_start
  );
endinterface

// File: rtl/led_pwm_dimmer_timebase.sv
// -----------------------------------------------------------------------------
// led_pwm_timebase
// PWM timebase: a prescaler that advances the PWM counter once every PRESCALE
// clocks, and a registered period marker.
//   CLK, RST_N     : clock, asynchronous active-low reset
//   pwm_cnt_o      : current PWM count (wraps modulo 2^PWM_BITS)
//   period_start_o : high for one cycle, in the first cycle pwm_cnt_o reads 0
//                    after a wrap (not after reset)
// -----------------------------------------------------------------------------
module led_pwm_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  output logic [PWM_BITS-1:0] pwm_cnt_o,
  output logic                period_start_o
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     prescaler_q, prescaler_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                period_start_q, period_start_d;
  logic                tick_s;

  // Next-state of prescaler, PWM counter and period marker.
  always_comb begin
    tick_s         = (prescaler_q == PS_LAST);
    prescaler_d    = prescaler_q + PS_W'(1);
    pwm_cnt_d      = pwm_cnt_q;
    period_start_d = 1'b0;
    if (tick_s) begin
      prescaler_d    = {PS_W{1'b0}};
      pwm_cnt_d      = pwm_cnt_q + PWM_BITS'(1);
      // Flag the edge where the counter rolls over so the pulse lines up
      // with the first cycle of count 0.
      period_start_d = (pwm_cnt_q == {PWM_BITS{1'b1}});
    end else begin
      pwm_cnt_d      = pwm_cnt_q;
      period_start_d = 1'b0;
    end
  end

  // Timebase state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prescaler_q    <= {PS_W{1'b0}};
      pwm_cnt_q      <= {PWM_BITS{1'b0}};
      period_start_q <= 1'b0;
    end else begin
      prescaler_q    <= prescaler_d;
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_cnt_o      = pwm_cnt_q;
  assign period_start_o = period_start_q;

endmodule

// File: rtl/led_pwm_dimmer.sv
// -----------------------------------------------------------------------------
// led_pwm_dimmer
// Accepts LED patterns over valid/ready and drives PWM-dimmed LED pins. Every
// new pattern is cross-faded: level ramps to 0, the pattern swaps, then the
// level ramps back up to the programmed brightness. Levels only move at PWM
// period boundaries.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : led_pwm_dimmer_if.slave (in_valid, in_ready, in_pattern,
//                brightness, led_out, busy, period_start)
// Build option: define LED_PWM_INVERT_EN for active-low LED boards (led_out
// inverted, reset value all ones); in_pattern bit = 1 still means "on".
// -----------------------------------------------------------------------------
module led_pwm_dimmer
  import led_pwm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PWM_BITS  = 8,
  parameter int PRESCALE  = 4,
  parameter int FADE_STEP = 16
) (
  input logic             CLK,
  input logic             RST_N,
  led_pwm_dimmer_if.slave bus
);

`ifdef LED_PWM_INVERT_EN
  localparam logic [WIDTH-1:0] LED_OFF = {WIDTH{1'b1}};
`else
  localparam logic [WIDTH-1:0] LED_OFF = {WIDTH{1'b0}};
`endif

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] target_q, target_d;
  logic [WIDTH-1:0]    active_q, active_d;
  logic [WIDTH-1:0]    pending_q, pending_d;
  logic [WIDTH-1:0]    led_q, led_d;
  logic [PWM_BITS-1:0] pwm_cnt_s;
  logic                period_start_s;
  logic [PWM_BITS-1:0] fade_up_s, fade_down_s;

  led_pwm_timebase #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .pwm_cnt_o      (pwm_cnt_s),
    .period_start_o (period_start_s)
  );

  // Cross-fade FSM: next state, level, target and pattern registers.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    active_d  = active_q;
    pending_d = pending_q;
    // Brightness is sampled at the period boundary and the freshly sampled
    // value is what the level moves towards in that same update.
    if (period_start_s) begin
      target_d = bus.brightness;
    end else begin
      target_d = target_q;
    end
    fade_up_s   = PWM_BITS'(sat_step(SAT_W'(level_q), SAT_W'(FADE_STEP), SAT_W'(target_d), 1'b1));
    fade_down_s = PWM_BITS'(sat_step(SAT_W'(level_q), SAT_W'(FADE_STEP), {SAT_W{1'b0}}, 1'b0));

    case (state_q)
      IDLE: begin
        if (period_start_s) begin
          level_d = target_d;
        end else begin
          level_d = level_q;
        end
        if (bus.in_valid) begin
          pending_d = bus.in_pattern;
          state_d   = FADE_OUT;
        end else begin
          state_d   = IDLE;
        end
      end
      FADE_OUT: begin
        if (period_start_s) begin
          if (level_q == {PWM_BITS{1'b0}}) begin
            state_d = SWAP;
          end else begin
            level_d = fade_down_s;
          end
        end else begin
          state_d = FADE_OUT;
        end
      end
      SWAP: begin
        active_d = pending_q;
        state_d  = FADE_IN;
      end
      FADE_IN: begin
        if (period_start_s) begin
          // Also covers a target lowered below the current level mid-fade.
          if (level_q >= target_d) begin
            level_d = target_d;
            state_d = IDLE;
          end else begin
            level_d = fade_up_s;
          end
        end else begin
          state_d = FADE_IN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // PWM compare: a lane is lit while the counter is below the level.
  always_comb begin
    if (pwm_cnt_s < level_q) begin
      led_d = active_q;
    end else begin
      led_d = {WIDTH{1'b0}};
    end
`ifdef LED_PWM_INVERT_EN
    led_d = ~led_d;
`endif
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      level_q   <= {PWM_BITS{1'b0}};
      target_q  <= {PWM_BITS{1'b0}};
      active_q  <= {WIDTH{1'b0}};
      pending_q <= {WIDTH{1'b0}};
      led_q     <= LED_OFF;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      target_q  <= target_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      led_q     <= led_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.period_start = period_start_s;
  assign bus.led_out      = led_q;

endmodule
